// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  localparam int unsigned CONSEC_W = 4;
  localparam int unsigned WDOG_W   = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between fetch/LSU requesters, the arbiter and the memory bus.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic              if_req_i;
  logic [AW-1:0]     if_addr_i;
  logic              if_ack_o;
  logic [DW-1:0]     if_rdata_o;
  logic              if_err_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [DW/8-1:0]   ls_be_i;
  logic [AW-1:0]     ls_addr_i;
  logic [DW-1:0]     ls_wdata_i;
  logic              ls_ack_o;
  logic [DW-1:0]     ls_rdata_o;
  logic              ls_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [DW/8-1:0]   mem_be_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_ack_i;
  logic [DW-1:0]     mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, if_err_o,
    output ls_ack_o, ls_rdata_o, ls_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, if_err_o,
    input  ls_ack_o, ls_rdata_o, ls_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// Bus timeout counter: counts enabled cycles, flags expiry on the TIMEOUT_CYC-th one.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WDOG_W-1:0] cnt;

  assign expire = enable && (cnt == WDOG_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, LS-priority with
// an anti-starvation limit. Bus timeout is built in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_LS_CONSEC = 4,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy_o,
  output logic              grant_o
);

  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_LS_CONSEC);

  state_t              state;
  logic [CONSEC_W-1:0] consec_cnt;
  logic                just_done;
  logic                ls_win, if_win;
  logic                timed_out, done;
  logic                if_own, ls_own;

  assign busy_o = (state == ST_BUSY);

`ifdef MEM_ARB_TIMEOUT_EN
  logic expire;

  mem_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!busy_o),
    .enable  (busy_o),
    .expire  (expire)
  );

  assign timed_out = expire && !bus.mem_ack_i;
`else
  assign timed_out = 1'b0;
`endif

  // The first IDLE cycle after a completion grants nobody, so the finished requester
  // (whose req may still be high) is masked and LS can keep its priority on re-request.
  always_comb begin
    ls_win = 1'b0;
    if_win = 1'b0;
    if (state == ST_IDLE && !just_done) begin
      ls_win = bus.ls_req_i && !(bus.if_req_i && consec_cnt == CONSEC_MAX);
      if_win = bus.if_req_i && !ls_win;
    end
  end

  assign done   = busy_o && (bus.mem_ack_i || timed_out);
  assign if_own = done && (grant_o == GRANT_IF);
  assign ls_own = done && (grant_o == GRANT_LS);

  assign bus.if_ack_o   = if_own;
  assign bus.if_err_o   = if_own && timed_out;
  assign bus.if_rdata_o = (if_own && !timed_out) ? bus.mem_rdata_i : '0;
  assign bus.ls_ack_o   = ls_own;
  assign bus.ls_err_o   = ls_own && timed_out;
  assign bus.ls_rdata_o = (ls_own && !timed_out) ? bus.mem_rdata_i : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      grant_o         <= GRANT_IF;
      just_done       <= 1'b0;
      consec_cnt      <= '0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_be_o    <= '0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          just_done <= 1'b0;
          if (ls_win) begin
            state           <= ST_BUSY;
            grant_o         <= GRANT_LS;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= bus.ls_we_i;
            bus.mem_be_o    <= bus.ls_be_i;
            bus.mem_addr_o  <= bus.ls_addr_i;
            bus.mem_wdata_o <= bus.ls_wdata_i;
            if (bus.if_req_i && consec_cnt != CONSEC_MAX) begin
              consec_cnt <= consec_cnt + 1'b1;
            end
          end else if (if_win) begin
            state           <= ST_BUSY;
            grant_o         <= GRANT_IF;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= 1'b0;
            bus.mem_be_o    <= '1;
            bus.mem_addr_o  <= bus.if_addr_i;
            bus.mem_wdata_o <= '0;
            consec_cnt      <= '0;
          end
        end
        ST_BUSY: begin
          if (done) begin
            state         <= ST_IDLE;
            bus.mem_req_o <= 1'b0;
            just_done     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, a delayed-ack memory model,
// and expected completions compared in order as acks appear.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ls_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy, grant;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        sb[$];
  logic [31:0] if_q[$];
  ls_t         ls_q[$];

  bit          if_done = 0;
  bit          ls_done = 0;
  bit          mem_en = 1;
  bit          spur_ack = 0;
  int unsigned ack_delay = 2;
  int unsigned wait_cnt = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW            (32),
    .DW            (32),
    .MAX_LS_CONSEC (4),
    .TIMEOUT_CYC   (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .busy_o  (busy),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_q.push_back(a);
  endtask

  task automatic issue_ls(input bit we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] d);
    ls_q.push_back('{we: we, be: be, addr: a, wdata: d});
  endtask

  task automatic exp_if(input logic [31:0] a);
    sb.push_back('{is_ls: 0, we: 0, be: 4'hF, addr: a, wdata: 32'h0, rdata: mem_word(a), err: 0});
  endtask

  task automatic exp_ls(input bit we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] d, input bit err);
    sb.push_back('{is_ls: 1, we: we, be: be, addr: a, wdata: d,
                   rdata: err ? 32'h0 : mem_word(a), err: err});
  endtask

  task automatic wait_drain(input int unsigned max_cyc);
    int unsigned n = 0;
    while ((sb.size() != 0 || if_q.size() != 0 || ls_q.size() != 0) && n < max_cyc) begin
      @(negedge clk); #3;
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    #3;
  endtask

  task automatic wait_busy(input int unsigned max_cyc);
    int unsigned n = 0;
    while (!busy && n < max_cyc) begin
      @(negedge clk); #3;
      n++;
    end
    check("wait_busy", 64'(busy), 64'd1);
  endtask

  // Requesters, memory model and completion monitor share one process for fixed ordering.
  initial begin
    ls_t  l;
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_done) begin bus.if_req_i = 1'b0; if_done = 0; end
      if (!bus.if_req_i && if_q.size() != 0) begin
        bus.if_addr_i = if_q.pop_front();
        bus.if_req_i  = 1'b1;
      end
      if (ls_done) begin bus.ls_req_i = 1'b0; ls_done = 0; end
      if (!bus.ls_req_i && ls_q.size() != 0) begin
        l = ls_q.pop_front();
        bus.ls_we_i    = l.we;
        bus.ls_be_i    = l.be;
        bus.ls_addr_i  = l.addr;
        bus.ls_wdata_i = l.wdata;
        bus.ls_req_i   = 1'b1;
      end
      if (spur_ack) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hBAD0_0BAD;
      end else if (bus.mem_req_o && mem_en) begin
        if (wait_cnt == ack_delay) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem_word(bus.mem_addr_o);
          wait_cnt = 0;
        end else begin
          bus.mem_ack_i   = 1'b0;
          bus.mem_rdata_i = $urandom();
          wait_cnt++;
        end
      end else begin
        bus.mem_ack_i = 1'b0;
        wait_cnt = 0;
      end
      #2;
      if (bus.if_ack_o || bus.ls_ack_o) begin
        check("ack_excl", 64'(bus.if_ack_o && bus.ls_ack_o), 64'd0);
        if (sb.size() == 0) begin
          check("unexp_ack", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("ack_port", 64'(bus.ls_ack_o), 64'(e.is_ls));
          check("grant", 64'(grant), 64'(e.is_ls));
          check("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
          check("mem_we", 64'(bus.mem_we_o), 64'(e.we));
          check("mem_be", 64'(bus.mem_be_o), 64'(e.be));
          check("mem_wdata", 64'(bus.mem_wdata_o), 64'(e.wdata));
          if (e.is_ls) begin
            check("ls_err", 64'(bus.ls_err_o), 64'(e.err));
            check("ls_rdata", 64'(bus.ls_rdata_o), 64'(e.rdata));
            check("if_rdata_idle", 64'(bus.if_rdata_o), 64'd0);
          end else begin
            check("if_err", 64'(bus.if_err_o), 64'(e.err));
            check("if_rdata", 64'(bus.if_rdata_o), 64'(e.rdata));
            check("ls_rdata_idle", 64'(bus.ls_rdata_o), 64'd0);
          end
        end
        if (bus.if_ack_o) if_done = 1;
        if (bus.ls_ack_o) ls_done = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.ls_req_i    = 1'b0;
    bus.ls_we_i     = 1'b0;
    bus.ls_be_i     = '0;
    bus.ls_addr_i   = '0;
    bus.ls_wdata_i  = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;

    // Reset state
    #3;
    check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we_o), 64'd0);
    check("rst_mem_be", 64'(bus.mem_be_o), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #3;

    // T1: single IF read, registered request latency, ack 2 cycles after mem_req_o
    ack_delay = 2;
    issue_if(32'h100);
    exp_if(32'h100);
    @(negedge clk); #3;
    check("t1_req_not_yet", 64'(bus.mem_req_o), 64'd0);
    @(negedge clk); #3;
    check("t1_mem_req", 64'(bus.mem_req_o), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_grant", 64'(grant), 64'd0);
    check("t1_be", 64'(bus.mem_be_o), 64'hF);
    check("t1_we", 64'(bus.mem_we_o), 64'd0);
    wait_drain(50);

    // T2: IF and LS store together -> LS first, then IF
    ack_delay = 1;
    issue_ls(1'b1, 4'h3, 32'h200, 32'h12345678);
    issue_if(32'h300);
    exp_ls(1'b1, 4'h3, 32'h200, 32'h12345678, 1'b0);
    exp_if(32'h300);
    wait_drain(60);

    // T3: IF waiting, LS requesting back to back -> 4 LS, IF, then remaining LS
    ack_delay = 0;
    issue_if(32'h400);
    for (int unsigned i = 0; i < 5; i++) begin
      issue_ls(1'b0, 4'hF, 32'h500 + 32'(i * 4), 32'h0);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      exp_ls(1'b0, 4'hF, 32'h500 + 32'(i * 4), 32'h0, 1'b0);
    end
    exp_if(32'h400);
    exp_ls(1'b0, 4'hF, 32'h510, 32'h0, 1'b0);
    wait_drain(100);
    check("t3_consec_clear", 64'(dut.consec_cnt), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // T4a: no ack -> timeout completion on BUSY cycle 8 with err
    mem_en = 0;
    issue_ls(1'b0, 4'hF, 32'h700, 32'h0);
    exp_ls(1'b0, 4'hF, 32'h700, 32'h0, 1'b1);
    wait_busy(20);
    repeat (6) @(negedge clk);
    #3;
    check("t4_no_ack_c7", 64'(bus.ls_ack_o), 64'd0);
    @(negedge clk); #3;
    check("t4_ack_c8", 64'(bus.ls_ack_o), 64'd1);
    check("t4_err_c8", 64'(bus.ls_err_o), 64'd1);
    @(negedge clk); #3;
    check("t4_req_drop", 64'(bus.mem_req_o), 64'd0);
    wait_drain(20);
    // T4b: ack exactly on cycle 8 -> normal completion
    mem_en = 1;
    ack_delay = 7;
    issue_ls(1'b0, 4'hF, 32'h704, 32'h0);
    exp_ls(1'b0, 4'hF, 32'h704, 32'h0, 1'b0);
    wait_drain(40);
`endif

    // T5: reset one cycle into BUSY, then a normal IF request
    mem_en = 0;
    issue_ls(1'b0, 4'hF, 32'h680, 32'h0);
    wait_busy(20);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    bus.ls_req_i = 1'b0;
    #1;
    check("t5_req_clear", 64'(bus.mem_req_o), 64'd0);
    check("t5_busy_clear", 64'(busy), 64'd0);
    check("t5_addr_clear", 64'(bus.mem_addr_o), 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    mem_en = 1;
    ack_delay = 1;
    repeat (2) @(negedge clk);
    #3;
    issue_if(32'h600);
    exp_if(32'h600);
    wait_drain(40);

    // T6: spurious mem_ack_i while IDLE -> nothing happens, arbiter still usable
    spur_ack = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      check("t6_if_ack", 64'(bus.if_ack_o), 64'd0);
      check("t6_ls_ack", 64'(bus.ls_ack_o), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
    end
    spur_ack = 0;
    @(negedge clk); #3;
    issue_if(32'h800);
    exp_if(32'h800);
    wait_drain(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
